// File: rtl/uart_core_p.sv
// Full-duplex UART with runtime baud divisor, configurable frame format,
// RX/TX FIFOs and sticky error flags.
module uart_core_p #(
  parameter int DIV_W     = 13,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_AW   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIV_W-1:0]   baud_div,
  input  logic               rx,
  output logic               tx,
  input  logic               rx_rden,
  output logic [7:0]         rx_rdata,
  output logic               rx_dvalid,
  output logic               rx_full,
  output logic [FIFO_AW:0]   rx_count,
  input  logic [7:0]         tx_wdata,
  input  logic               tx_wten,
  output logic               tx_full,
  output logic [FIFO_AW:0]   tx_count,
  output logic               tx_busy,
  input  logic               err_clr,
  output logic               err_frame,
  output logic               err_parity,
  output logic               err_overrun
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;

  // RX input conditioning: synchroniser, 5-tap history and majority vote
  logic [1:0] rx_sync;
  logic [4:0] rx_taps;
  logic [2:0] rx_ones;
  logic       rx_sample;
  logic       rx_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync <= 2'b11;
      rx_taps <= 5'b11111;
    end else begin
      rx_sync <= {rx_sync[0], rx};
      rx_taps <= {rx_taps[3:0], rx_sync[1]};
    end
  end

  always_comb begin
    rx_ones   = 3'(rx_taps[0]) + 3'(rx_taps[1]) + 3'(rx_taps[2])
              + 3'(rx_taps[3]) + 3'(rx_taps[4]);
    rx_sample = (rx_ones >= 3'd3);
    rx_fall   = rx_taps[0] & ~rx_sync[1];
  end

  rx_state_t              rx_state;
  logic [DIV_W-1:0]       rx_cnt;
  logic [DIV_W-1:0]       rx_div;
  logic [2:0]             rx_bit;
  logic [DATA_BITS-1:0]   rx_shift;
  logic                   rx_par_bit;
  logic                   rx_push_req;
  logic                   rx_push_par_err;
  logic                   rx_frame_err;

  // Frame results are registered pulses consumed by the FIFO and flags next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state        <= RX_IDLE;
      rx_cnt          <= '0;
      rx_div          <= '0;
      rx_bit          <= '0;
      rx_shift        <= '0;
      rx_par_bit      <= 1'b0;
      rx_push_req     <= 1'b0;
      rx_push_par_err <= 1'b0;
      rx_frame_err    <= 1'b0;
    end else begin
      rx_push_req  <= 1'b0;
      rx_frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_cnt   <= baud_div >> 1;
            rx_div   <= baud_div;
            rx_state <= RX_START;
          end
        end
        default: begin
          if (rx_cnt == CNT_ONE) begin
            rx_cnt <= rx_div;
            case (rx_state)
              RX_START: begin
                if (rx_sample) begin
                  rx_state <= RX_IDLE;
                end else begin
                  rx_state <= RX_DATA;
                  rx_bit   <= '0;
                end
              end
              RX_DATA: begin
                rx_shift <= {rx_sample, rx_shift[DATA_BITS-1:1]};
                if (rx_bit == LAST_BIT) begin
                  rx_state <= (PARITY != 0) ? RX_PAR : RX_STOP;
                end else begin
                  rx_bit <= rx_bit + 3'd1;
                end
              end
              RX_PAR: begin
                rx_par_bit <= rx_sample;
                rx_state   <= RX_STOP;
              end
              RX_STOP: begin
                if (rx_sample) begin
                  rx_push_req     <= 1'b1;
                  rx_push_par_err <= (PARITY != 0) &&
                    (rx_par_bit != ((PARITY == 2) ? ^rx_shift : ~^rx_shift));
                end else begin
                  rx_frame_err <= 1'b1;
                end
                rx_state <= RX_IDLE;
              end
              default: rx_state <= RX_IDLE;
            endcase
          end else begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end
        end
      endcase
    end
  end

  // RX FIFO: a pop frees the slot so a full FIFO still accepts a same-cycle push
  logic [DATA_BITS-1:0] rx_mem [DEPTH];
  logic [FIFO_AW-1:0]   rx_wr;
  logic [FIFO_AW-1:0]   rx_rd;
  logic                 rx_pop;
  logic                 rx_push;
  logic                 rx_ovr;

  always_comb begin
    rx_dvalid = (rx_count != '0);
    rx_full   = (rx_count == FULL_CNT);
    rx_pop    = rx_rden && rx_dvalid;
    rx_push   = rx_push_req && (!rx_full || rx_pop);
    rx_ovr    = rx_push_req && rx_full && !rx_pop;
    rx_rdata  = '0;
    if (rx_dvalid) rx_rdata[DATA_BITS-1:0] = rx_mem[rx_rd];
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr] <= rx_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      rx_count <= rx_count + (FIFO_AW+1)'(rx_push) - (FIFO_AW+1)'(rx_pop);
    end
  end

  // TX FIFO
  logic [DATA_BITS-1:0] tx_mem [DEPTH];
  logic [FIFO_AW-1:0]   tx_wr;
  logic [FIFO_AW-1:0]   tx_rd;
  logic                 tx_push;
  logic                 tx_pop;
  logic                 tx_ovr;
  logic [DATA_BITS-1:0] tx_head;

  tx_state_t            tx_state;
  logic [DIV_W-1:0]     tx_cnt;
  logic [DIV_W-1:0]     tx_div;
  logic [2:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 tx_stop_idx;
  logic                 tx_last_stop;

  always_comb begin
    tx_full      = (tx_count == FULL_CNT);
    tx_push      = tx_wten && !tx_full;
    tx_ovr       = tx_wten && tx_full;
    tx_head      = tx_mem[tx_rd];
    tx_last_stop = (STOP_BITS == 1) || tx_stop_idx;
    tx_pop       = (tx_count != '0) &&
                   ((tx_state == TX_IDLE) ||
                    ((tx_state == TX_STOP) && (tx_cnt == CNT_ONE) && tx_last_stop));
    tx_busy      = (tx_state != TX_IDLE);
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= tx_wdata[DATA_BITS-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      tx_count <= tx_count + (FIFO_AW+1)'(tx_push) - (FIFO_AW+1)'(tx_pop);
    end
  end

  // A pop always starts a new frame, which also chains frames with no idle gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state    <= TX_IDLE;
      tx          <= 1'b1;
      tx_cnt      <= '0;
      tx_div      <= '0;
      tx_bit      <= '0;
      tx_shift    <= '0;
      tx_par      <= 1'b0;
      tx_stop_idx <= 1'b0;
    end else if (tx_pop) begin
      tx_state <= TX_START;
      tx       <= 1'b0;
      tx_cnt   <= baud_div;
      tx_div   <= baud_div;
      tx_shift <= tx_head;
      tx_par   <= (PARITY == 2) ? ^tx_head : ~^tx_head;
    end else begin
      case (tx_state)
        TX_IDLE: tx <= 1'b1;
        default: begin
          if (tx_cnt == CNT_ONE) begin
            tx_cnt <= tx_div;
            case (tx_state)
              TX_START: begin
                tx_state <= TX_DATA;
                tx       <= tx_shift[0];
                tx_bit   <= '0;
              end
              TX_DATA: begin
                if (tx_bit == LAST_BIT) begin
                  if (PARITY != 0) begin
                    tx_state <= TX_PAR;
                    tx       <= tx_par;
                  end else begin
                    tx_state    <= TX_STOP;
                    tx          <= 1'b1;
                    tx_stop_idx <= 1'b0;
                  end
                end else begin
                  tx_bit   <= tx_bit + 3'd1;
                  tx       <= tx_shift[1];
                  tx_shift <= tx_shift >> 1;
                end
              end
              TX_PAR: begin
                tx_state    <= TX_STOP;
                tx          <= 1'b1;
                tx_stop_idx <= 1'b0;
              end
              TX_STOP: begin
                if (tx_last_stop) begin
                  tx_state <= TX_IDLE;
                end else begin
                  tx_stop_idx <= 1'b1;
                end
                tx <= 1'b1;
              end
              default: begin
                tx_state <= TX_IDLE;
                tx       <= 1'b1;
              end
            endcase
          end else begin
            tx_cnt <= tx_cnt - CNT_ONE;
          end
        end
      endcase
    end
  end

  // Sticky flags: a new error in the clearing cycle keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_frame   <= 1'b0;
      err_parity  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (rx_frame_err)      err_frame <= 1'b1;
      else if (err_clr)      err_frame <= 1'b0;
      if (rx_push_req && rx_push_par_err) err_parity <= 1'b1;
      else if (err_clr)      err_parity <= 1'b0;
      if (rx_ovr || tx_ovr)  err_overrun <= 1'b1;
      else if (err_clr)      err_overrun <= 1'b0;
    end
  end

endmodule
